// File: rtl/dmem_access_unit.sv
// Multi-cycle data-memory access unit: accepts one hart load/store, checks alignment/legality,
// runs a valid/ready memory transaction and returns an extended load result with a done pulse.
module dmem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_ren,
    input  logic        i_req_wen,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [2:0]  i_req_funct3,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_trap,
    output logic [31:0] o_rdata,
    output logic        o_mem_valid,
    input  logic        i_mem_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] tmo_cnt;
    logic [1:0]       req_off;
    logic [2:0]       req_funct3;

    logic [1:0]  in_off_c;
    logic        in_trap_c;
    logic [3:0]  in_mask_c;
    logic [31:0] in_wdata_c;
    logic [31:0] rd_shift_c;
    logic [31:0] load_data_c;
    logic        tmo_hit_c;

    // Acceptance-time legality checks and lane placement of the incoming request
    always_comb begin
        in_off_c   = i_req_addr[1:0];
        in_trap_c  = 1'b0;
        in_mask_c  = 4'b1111;
        in_wdata_c = i_req_wdata << {in_off_c, 3'b000};
        if (i_req_ren && i_req_wen) begin
            in_trap_c = 1'b1;
        end
        if (i_req_ren && (i_req_funct3 == 3'd3 || i_req_funct3 == 3'd6 || i_req_funct3 == 3'd7)) begin
            in_trap_c = 1'b1;
        end
        if (i_req_wen && i_req_funct3 > 3'd2) begin
            in_trap_c = 1'b1;
        end
        case (i_req_funct3[1:0])
            2'd0: in_mask_c = 4'b0001 << in_off_c;
            2'd1: begin
                in_mask_c = 4'b0011 << in_off_c;
                if (in_off_c[0]) in_trap_c = 1'b1;
            end
            default: begin
                in_mask_c = 4'b1111;
                if (in_off_c != 2'd0) in_trap_c = 1'b1;
            end
        endcase
    end

    // Lane extraction and sign/zero extension of the returned read word
    always_comb begin
        rd_shift_c  = i_mem_rdata >> {req_off, 3'b000};
        load_data_c = rd_shift_c;
        case (req_funct3)
            3'd0:    load_data_c = {{24{rd_shift_c[7]}}, rd_shift_c[7:0]};
            3'd1:    load_data_c = {{16{rd_shift_c[15]}}, rd_shift_c[15:0]};
            3'd4:    load_data_c = {24'd0, rd_shift_c[7:0]};
            3'd5:    load_data_c = {16'd0, rd_shift_c[15:0]};
            default: load_data_c = rd_shift_c;
        endcase
    end

    // A completing handshake or rvalid in the final budgeted cycle still wins over the timeout
    assign tmo_hit_c = (tmo_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            tmo_cnt     <= '0;
            req_off     <= 2'd0;
            req_funct3  <= 3'd0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_trap      <= 1'b0;
            o_rdata     <= 32'd0;
            o_mem_valid <= 1'b0;
            o_mem_addr  <= 32'd0;
            o_mem_ren   <= 1'b0;
            o_mem_wen   <= 1'b0;
            o_mem_wdata <= 32'd0;
            o_mem_mask  <= 4'd0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_req_ren || i_req_wen) begin
                        req_off    <= i_req_addr[1:0];
                        req_funct3 <= i_req_funct3;
                        o_busy     <= 1'b1;
                        if (in_trap_c) begin
                            state  <= S_DONE;
                            o_done <= 1'b1;
                            o_trap <= 1'b1;
                        end else begin
                            state       <= S_REQ;
                            tmo_cnt     <= '0;
                            o_mem_valid <= 1'b1;
                            o_mem_addr  <= {i_req_addr[31:2], 2'b00};
                            o_mem_ren   <= i_req_ren;
                            o_mem_wen   <= i_req_wen;
                            o_mem_wdata <= in_wdata_c;
                            o_mem_mask  <= in_mask_c;
                        end
                    end
                end
                S_REQ: begin
                    if (i_mem_ready || tmo_hit_c) begin
                        o_mem_valid <= 1'b0;
                        o_mem_ren   <= 1'b0;
                        o_mem_wen   <= 1'b0;
                    end
                    if (i_mem_ready) begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                        if (o_mem_wen) begin
                            state  <= S_DONE;
                            o_done <= 1'b1;
                            o_trap <= 1'b0;
                        end else begin
                            state <= S_WAIT;
                        end
                    end else if (tmo_hit_c) begin
                        state  <= S_DONE;
                        o_done <= 1'b1;
                        o_trap <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (i_mem_rvalid) begin
                        state   <= S_DONE;
                        o_done  <= 1'b1;
                        o_trap  <= 1'b0;
                        o_rdata <= load_data_c;
                    end else if (tmo_hit_c) begin
                        state  <= S_DONE;
                        o_done <= 1'b1;
                        o_trap <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                    o_trap <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed plan cases plus randomized accesses
// compared against an arithmetic reference model of the access rules.
module tb_dmem_access_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;
    logic        req_ren, req_wen;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_f3;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;

    logic        m_busy, m_done, m_trap, m_mem_valid, m_mem_ren, m_mem_wen;
    logic [31:0] m_rdata, m_mem_addr, m_mem_wdata;
    logic [3:0]  m_mem_mask;
    logic        t_busy, t_done, t_trap, t_mem_valid, t_mem_ren, t_mem_wen;
    logic [31:0] t_rdata, t_mem_addr, t_mem_wdata;
    logic [3:0]  t_mem_mask;

    dmem_access_unit u_main (
        .i_clk(clk), .i_rst(rst),
        .i_req_ren(req_ren & ~sel), .i_req_wen(req_wen & ~sel),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_funct3(req_f3),
        .o_busy(m_busy), .o_done(m_done), .o_trap(m_trap), .o_rdata(m_rdata),
        .o_mem_valid(m_mem_valid), .i_mem_ready(mem_ready), .o_mem_addr(m_mem_addr),
        .o_mem_ren(m_mem_ren), .o_mem_wen(m_mem_wen), .o_mem_wdata(m_mem_wdata),
        .o_mem_mask(m_mem_mask), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
    );

    dmem_access_unit #(.TIMEOUT_CYCLES(4)) u_tmo (
        .i_clk(clk), .i_rst(rst),
        .i_req_ren(req_ren & sel), .i_req_wen(req_wen & sel),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_funct3(req_f3),
        .o_busy(t_busy), .o_done(t_done), .o_trap(t_trap), .o_rdata(t_rdata),
        .o_mem_valid(t_mem_valid), .i_mem_ready(mem_ready), .o_mem_addr(t_mem_addr),
        .o_mem_ren(t_mem_ren), .o_mem_wen(t_mem_wen), .o_mem_wdata(t_mem_wdata),
        .o_mem_mask(t_mem_mask), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
    );

    logic        o_busy_s, o_done_s, o_trap_s, o_valid_s, o_ren_s, o_wen_s;
    logic [31:0] o_rdata_s, o_addr_s, o_wdata_s;
    logic [3:0]  o_mask_s;
    assign o_busy_s  = sel ? t_busy      : m_busy;
    assign o_done_s  = sel ? t_done      : m_done;
    assign o_trap_s  = sel ? t_trap      : m_trap;
    assign o_valid_s = sel ? t_mem_valid : m_mem_valid;
    assign o_ren_s   = sel ? t_mem_ren   : m_mem_ren;
    assign o_wen_s   = sel ? t_mem_wen   : m_mem_wen;
    assign o_rdata_s = sel ? t_rdata     : m_rdata;
    assign o_addr_s  = sel ? t_mem_addr  : m_mem_addr;
    assign o_wdata_s = sel ? t_mem_wdata : m_mem_wdata;
    assign o_mask_s  = sel ? t_mem_mask  : m_mem_mask;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] hold [2];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference model: access size in bytes from funct3
    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit model_trap(input bit ren, input bit wen, input logic [31:0] addr, input logic [2:0] f3);
        if (ren && wen) return 1'b1;
        if (ren && (f3 == 3'd3 || f3 >= 3'd6)) return 1'b1;
        if (wen && f3 > 3'd2) return 1'b1;
        return (addr % size_of(f3)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] addr, input logic [2:0] f3);
        int     nb  = size_of(f3);
        longint v   = longint'(word) >> (8 * (addr % 4));
        longint lim = longint'(1) << (8 * nb);
        v = v % lim;
        if (!f3[2] && nb < 4 && v >= lim / 2) v = v - lim;
        return 32'(v);
    endfunction

    // One hart access from request to the idle cycle after o_done, on the unit picked by s
    task automatic run_access(input string name, input bit s, input bit ren, input bit wen,
                              input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3,
                              input int rdy, input int rv, input logic [31:0] word);
        bit          trap     = model_trap(ren, wen, addr, f3);
        int          lim      = s ? 4 : 255;
        int          needed   = (rdy + 1) + (ren ? rv + 1 : 0);
        bit          to       = !trap && needed > lim;
        int          exp_cyc  = trap ? 1 : (to ? lim + 1 : needed + 1);
        int          exp_vcnt = trap ? 0 : rdy + 1;
        logic [31:0] exp_rd   = (ren && !trap && !to) ? model_load(word, addr, f3) : hold[s];
        int          cyc = 0, vcnt = 0, wcnt = 0;
        bit          hs = 0, fin = 0;

        sel = s; req_ren = ren; req_wen = wen; req_addr = addr; req_wdata = wdata; req_f3 = f3;
        mem_ready = 0; mem_rvalid = 0;
        @(posedge clk);
        while (!fin) begin
            @(negedge clk);
            cyc++;
            if (cyc > 600) begin
                check({name, ".no_done"}, 32'(o_done_s), 32'd1);
                break;
            end
            if (o_done_s) begin
                fin = 1;
                check({name, ".done_cycle"}, 32'(cyc), 32'(exp_cyc));
                check({name, ".trap"}, 32'(o_trap_s), 32'(trap || to));
                check({name, ".rdata"}, o_rdata_s, exp_rd);
                check({name, ".valid_cycles"}, 32'(vcnt), 32'(exp_vcnt));
                check({name, ".valid_at_done"}, 32'(o_valid_s), 32'd0);
                hold[s] = exp_rd;
                req_ren = 0; req_wen = 0; mem_ready = 0; mem_rvalid = 0;
            end else begin
                check({name, ".busy"}, 32'(o_busy_s), 32'd1);
                if (o_valid_s) begin
                    vcnt++;
                    check({name, ".addr"}, o_addr_s, addr - (addr % 4));
                    check({name, ".mask"}, 32'(o_mask_s), 32'(((1 << size_of(f3)) - 1) << (addr % 4)));
                    check({name, ".ren"}, 32'(o_ren_s), 32'(ren));
                    check({name, ".wen"}, 32'(o_wen_s), 32'(wen));
                    if (wen) check({name, ".wdata"}, o_wdata_s, 32'(longint'(wdata) << (8 * (addr % 4))));
                end else begin
                    check({name, ".idle_rw"}, {30'd0, o_ren_s, o_wen_s}, 32'd0);
                end
                mem_ready = o_valid_s && (vcnt == rdy + 1);
                if (hs) begin
                    wcnt++;
                    mem_rvalid = (wcnt == rv + 1);
                    mem_rdata  = mem_rvalid ? word : $urandom;
                end else begin
                    // stray rvalid while the request is still pending must be ignored
                    mem_rvalid = !mem_ready && ($urandom_range(0, 1) == 1);
                    mem_rdata  = $urandom;
                end
                if (mem_ready) hs = 1;
            end
        end
        @(negedge clk);
        check({name, ".after_done"}, 32'(o_done_s), 32'd0);
        check({name, ".after_busy"}, 32'(o_busy_s), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1; sel = 0; req_ren = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_f3 = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
        hold[0] = 0; hold[1] = 0;
        repeat (3) @(negedge clk);
        check("reset.busy", 32'(m_busy), 32'd0);
        check("reset.done", 32'(m_done), 32'd0);
        check("reset.trap", 32'(m_trap), 32'd0);
        check("reset.rdata", m_rdata, 32'd0);
        check("reset.valid", 32'(m_mem_valid), 32'd0);
        check("reset.addr", m_mem_addr, 32'd0);
        check("reset.mask", 32'(m_mem_mask), 32'd0);
        rst = 0;
        @(negedge clk);

        run_access("lw_slow", 0, 1, 0, 32'h1000, 32'h0, 3'd2, 2, 0, 32'hDEADBEEF);
        run_access("lb_hi",   0, 1, 0, 32'h1003, 32'h0, 3'd0, 0, 0, 32'h80123456);
        run_access("lbu_hi",  0, 1, 0, 32'h1003, 32'h0, 3'd4, 0, 0, 32'h80123456);
        run_access("sh_hi",   0, 0, 1, 32'h2002, 32'h1234ABCD, 3'd1, 0, 0, 32'h0);
        run_access("lw_mis",  0, 1, 0, 32'h1001, 32'h0, 3'd2, 0, 0, 32'h0);
        run_access("sh_mis",  0, 0, 1, 32'h2003, 32'h5555AAAA, 3'd1, 0, 0, 32'h0);
        run_access("rw_both", 0, 1, 1, 32'h1000, 32'h0, 3'd2, 0, 0, 32'h0);
        run_access("ld_f3_3", 0, 1, 0, 32'h1000, 32'h0, 3'd3, 0, 0, 32'h0);
        run_access("st_f3_4", 0, 0, 1, 32'h1000, 32'h0, 3'd4, 0, 0, 32'h0);

        // Timeout on the short-budget unit, preceded by a good load so held data is non-zero
        run_access("to_prime", 1, 1, 0, 32'h0040, 32'h0, 3'd2, 0, 0, 32'h13572468);
        run_access("to_load",  1, 1, 0, 32'h1000, 32'h0, 3'd2, 0, 1000, 32'h0);
        mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
        repeat (2) begin
            @(negedge clk);
            check("late_rv.busy", 32'(t_busy), 32'd0);
            check("late_rv.done", 32'(t_done), 32'd0);
            check("late_rv.rdata", t_rdata, hold[1]);
        end
        mem_rvalid = 0;

        for (int i = 0; i < 40; i++) begin
            int          kind = $urandom_range(0, 7);
            bit          ren  = (kind == 0) || (kind > 3);
            bit          wen  = (kind >= 0) && (kind <= 3);
            logic [2:0]  f3   = 3'($urandom_range(0, 7));
            logic [31:0] a    = $urandom;
            if ($urandom_range(0, 2) != 0) a = a - (a % size_of(f3));
            run_access($sformatf("rnd%0d", i), 0, ren, wen, a, $urandom, f3,
                       $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        // Reset while waiting for read data aborts the access silently
        sel = 0; req_ren = 1; req_wen = 0; req_addr = 32'h3000; req_f3 = 3'd2;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid.valid", 32'(m_mem_valid), 32'd1);
        mem_ready = 1;
        @(negedge clk);
        mem_ready = 0; req_ren = 0;
        check("rst_mid.in_wait", 32'(m_busy), 32'd1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        hold[0] = 0; hold[1] = 0;
        check("rst_mid.busy", 32'(m_busy), 32'd0);
        check("rst_mid.done", 32'(m_done), 32'd0);
        check("rst_mid.valid_off", 32'(m_mem_valid), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("rst_mid.quiet", {30'd0, m_done, m_mem_valid}, 32'd0);
        end
        run_access("lhu_after_rst", 0, 1, 0, 32'h3002, 32'h0, 3'd5, 0, 0, 32'hF00D0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
